c2f_chunk_buffer: RTL and testbench

C2F_CHUNK_BUFFER -- requirements
Module: c2f_chunk_buffer

---
 rtl/tlp_xcvr_pkg.sv | 11 +
 rtl/c2f_chunk_buffer.sv | 107 ++++++++++
 tb/tb_c2f_chunk_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared C2F geometry for the TLP transceiver: chunk index and QW-offset types.
package tlp_xcvr_pkg;

  localparam int unsigned C2F_CHUNKSIZE = 128;
  localparam int unsigned C2F_CI_W      = 2;
  localparam int unsigned C2F_CO_W      = $clog2(C2F_CHUNKSIZE / 8);

  typedef logic [C2F_CI_W-1:0] C2FChunkIndex;
  typedef logic [C2F_CO_W-1:0] C2FChunkOffset;

endpackage

// File: rtl/c2f_chunk_buffer.sv
// Card-to-FPGA chunk ring: host fills and commits chunks, consumer reads and acks them.
// One slot is always kept empty so equal indices unambiguously mean empty.
module c2f_chunk_buffer
  import tlp_xcvr_pkg::*;
#(
  parameter bit STRICT_COMMIT = 1'b1
) (
  input  logic          sysClk_in,
  input  logic          sysReset_in,
  input  logic          wrValid_in,
  input  C2FChunkIndex  wrChunk_in,
  input  C2FChunkOffset wrOffset_in,
  input  logic [63:0]   wrData_in,
  input  logic          commit_in,
  output C2FChunkIndex  wrIndex_out,
  output C2FChunkIndex  rdIndex_out,
  input  logic          dtAck_in,
  input  C2FChunkOffset rdOffset_in,
  output logic [63:0]   rdData_out,
  output logic          full_out,
  output logic [3:0]    errFlags_out
);

  localparam int unsigned CI         = $bits(C2FChunkIndex);
  localparam int unsigned CO         = $bits(C2FChunkOffset);
  localparam int unsigned NUM_CHUNKS = 2 ** CI;
  localparam int unsigned CHUNK_QWS  = 2 ** CO;
  localparam int unsigned DEPTH      = NUM_CHUNKS * CHUNK_QWS;

  C2FChunkIndex         wr_idx_q, wr_idx_d;
  C2FChunkIndex         rd_idx_q, rd_idx_d;
  logic [CHUNK_QWS-1:0] map_q, map_d;
  logic [3:0]           err_q, err_d;
  logic [63:0]          rd_data_q;
  logic [63:0]          mem_q [DEPTH];

  logic                 full;
  logic                 wr_accept;
  logic [CHUNK_QWS-1:0] map_set;
  logic [CHUNK_QWS-1:0] map_with;
  logic                 map_complete;
  logic                 commit_ok;
  logic                 commit_rej;
  logic                 ack_ok;
  logic                 ack_under;

  always_comb begin
    full      = (C2FChunkIndex'(wr_idx_q + 1'b1) == rd_idx_q);
    wr_accept = wrValid_in && (wrChunk_in == wr_idx_q) && !full;

    map_set = '0;
    if (wr_accept) begin
      map_set[wrOffset_in] = 1'b1;
    end
    // A write landing in the commit cycle counts toward completeness.
    map_with     = map_q | map_set;
    map_complete = &map_with;

    commit_ok  = commit_in && !full && (!STRICT_COMMIT || map_complete);
    commit_rej = commit_in && !commit_ok;
    ack_ok     = dtAck_in && (wr_idx_q != rd_idx_q);
    ack_under  = dtAck_in && (wr_idx_q == rd_idx_q);

    wr_idx_d = commit_ok ? C2FChunkIndex'(wr_idx_q + 1'b1) : wr_idx_q;
    rd_idx_d = ack_ok ? C2FChunkIndex'(rd_idx_q + 1'b1) : rd_idx_q;
    map_d    = commit_ok ? '0 : map_with;
    err_d    = err_q | {commit_ok && !map_complete, ack_under, commit_rej,
                        wrValid_in && !wr_accept};
  end

  always_ff @(posedge sysClk_in or posedge sysReset_in) begin
    if (sysReset_in) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      map_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      map_q    <= map_d;
      err_q    <= err_d;
    end
  end

  // RAM is deliberately not reset; a reset only discards chunks via the indices.
  always_ff @(posedge sysClk_in) begin
    if (wr_accept) begin
      mem_q[{wr_idx_q, wrOffset_in}] <= wrData_in;
    end
  end

  // Same-address read during a write returns the pre-write contents.
  always_ff @(posedge sysClk_in or posedge sysReset_in) begin
    if (sysReset_in) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[{rd_idx_q, rdOffset_in}];
    end
  end

  assign wrIndex_out  = wr_idx_q;
  assign rdIndex_out  = rd_idx_q;
  assign rdData_out   = rd_data_q;
  assign full_out     = full;
  assign errFlags_out = err_q;

endmodule

// File: tb/tb_c2f_chunk_buffer.sv
// Directed bench for c2f_chunk_buffer: fill/commit/ack, full, errors, wrap and async reset.
module tb_c2f_chunk_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid;
  logic [1:0]  wr_chunk;
  logic [3:0]  wr_offset;
  logic [63:0] wr_data;
  logic        commit;
  logic [1:0]  wr_index;
  logic [1:0]  rd_index;
  logic        dt_ack;
  logic [3:0]  rd_offset;
  logic [63:0] rd_data;
  logic        full;
  logic [3:0]  err_flags;

  int vectors     = 0;
  int miscompares = 0;

  c2f_chunk_buffer dut (
    .sysClk_in   (clk),
    .sysReset_in (rst),
    .wrValid_in  (wr_valid),
    .wrChunk_in  (wr_chunk),
    .wrOffset_in (wr_offset),
    .wrData_in   (wr_data),
    .commit_in   (commit),
    .wrIndex_out (wr_index),
    .rdIndex_out (rd_index),
    .dtAck_in    (dt_ack),
    .rdOffset_in (rd_offset),
    .rdData_out  (rd_data),
    .full_out    (full),
    .errFlags_out(err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    commit   = 1'b0;
    dt_ack   = 1'b0;
  endtask

  // Writes n consecutive QWs from offset first, data = base + offset; optional commit on the last.
  task automatic fill(input logic [1:0] ch, input logic [63:0] base, input int first,
                      input int n, input bit commit_last);
    for (int o = first; o < first + n; o++) begin
      wr_valid  = 1'b1;
      wr_chunk  = ch;
      wr_offset = o[3:0];
      wr_data   = base + 64'(o);
      commit    = commit_last && (o == first + n - 1);
      step();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    wr_chunk  = '0;
    wr_offset = '0;
    wr_data   = '0;
    rd_offset = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_wr_index", 64'(wr_index), 64'd0);
    check("rst_rd_index", 64'(rd_index), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_err", 64'(err_flags), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full chunk 0, data = offset+1
    fill(2'd0, 64'd1, 0, 16, 1'b1);
    check("c0_commit_wr_index", 64'(wr_index), 64'd1);
    check("c0_err", 64'(err_flags), 64'd0);
    check("c0_not_full", 64'(full), 64'd0);
    rd_offset = 4'd5;
    step();
    check("c0_read_off5", rd_data, 64'd6);

    // Strict commit with one QW missing, then the missing QW with a same-cycle commit
    fill(2'd1, 64'h100, 0, 15, 1'b0);
    commit = 1'b1;
    step();
    idle();
    check("partial_commit_wr_index", 64'(wr_index), 64'd1);
    check("partial_commit_err", 64'(err_flags), 64'h2);
    fill(2'd1, 64'h100, 15, 1, 1'b1);
    check("samecycle_commit_wr_index", 64'(wr_index), 64'd2);

    // Third pending chunk makes the ring full
    fill(2'd2, 64'h200, 0, 16, 1'b1);
    check("full_wr_index", 64'(wr_index), 64'd3);
    check("full_flag", 64'(full), 64'd1);
    fill(2'd3, 64'h300, 0, 1, 1'b0);
    check("full_write_dropped_err", 64'(err_flags), 64'h3);
    commit = 1'b1;
    step();
    idle();
    check("full_commit_rejected", 64'(wr_index), 64'd3);

    // Commit and ack together while full: ack wins, commit rejected on pre-update full
    commit = 1'b1;
    dt_ack = 1'b1;
    step();
    idle();
    check("cmt_ack_rd_index", 64'(rd_index), 64'd1);
    check("cmt_ack_wr_index", 64'(wr_index), 64'd3);
    check("cmt_ack_full", 64'(full), 64'd0);
    check("cmt_ack_err", 64'(err_flags), 64'h3);

    dt_ack = 1'b1;
    step();
    idle();
    check("ack_rd_index_2", 64'(rd_index), 64'd2);
    rd_offset = 4'd9;
    step();
    check("c2_read_off9", rd_data, 64'h209);
    dt_ack = 1'b1;
    step();
    idle();
    check("ack_rd_index_3", 64'(rd_index), 64'd3);
    dt_ack = 1'b1;
    step();
    idle();
    check("ack_underflow_rd_index", 64'(rd_index), 64'd3);
    check("ack_underflow_err", 64'(err_flags), 64'h7);
    check("empty_not_full", 64'(full), 64'd0);

    // Eight fill/commit/ack pairs: both indices wrap twice
    for (int p = 0; p < 8; p++) begin
      fill(2'(3 + p), 64'hC0DE_0000 + 64'(p * 16), 0, 16, 1'b1);
      dt_ack = 1'b1;
      step();
      idle();
      if (p == 0) begin
        check("wrap_wr_index", 64'(wr_index), 64'd0);
        check("wrap_rd_index", 64'(rd_index), 64'd0);
      end
    end
    check("pairs_wr_index", 64'(wr_index), 64'd3);
    check("pairs_rd_index", 64'(rd_index), 64'd3);
    check("pairs_err", 64'(err_flags), 64'h7);

    // Async reset mid-chunk, between clock edges
    fill(2'd3, 64'h300, 0, 8, 1'b0);
    wr_valid  = 1'b1;
    wr_chunk  = 2'd3;
    wr_offset = 4'd8;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_wr_index", 64'(wr_index), 64'd0);
    check("midrst_rd_index", 64'(rd_index), 64'd0);
    check("midrst_full", 64'(full), 64'd0);
    check("midrst_err", 64'(err_flags), 64'd0);
    check("midrst_rd_data", rd_data, 64'd0);
    idle();
    rd_offset = 4'd5;
    @(negedge clk);
    rst = 1'b0;

    // Map must be clear: upper half alone cannot commit
    fill(2'd0, 64'hA00, 8, 8, 1'b1);
    check("postrst_half_commit_wr_index", 64'(wr_index), 64'd0);
    check("postrst_half_commit_err", 64'(err_flags), 64'h2);
    fill(2'd0, 64'hA00, 5, 1, 1'b0);
    check("same_addr_old_data", rd_data, 64'hC0DE_0055);
    fill(2'd0, 64'hA00, 0, 5, 1'b0);
    check("same_addr_new_data", rd_data, 64'hA05);
    fill(2'd0, 64'hA00, 6, 2, 1'b1);
    check("postrst_commit_wr_index", 64'(wr_index), 64'd1);
    check("postrst_commit_err", 64'(err_flags), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
